// File: rtl/ysyx_23060184_axi_sram_pkg.sv
// rtl/ysyx_23060184_axi_sram_pkg.sv - shared constants and state encoding for the AXI4-Lite SRAM slave
package ysyx_23060184_axi_sram_pkg;

    localparam logic [1:0]  RESP_OKAY         = 2'b00;
    localparam logic [1:0]  RESP_SLVERR       = 2'b10;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

endpackage

// File: rtl/ysyx_23060184_sram_array.sv
// rtl/ysyx_23060184_sram_array.sv - single-port word array with byte write enables and registered read
module ysyx_23060184_sram_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             re,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write and registered read; rdata holds until the next read
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ysyx_23060184_axi_sram.sv
// rtl/ysyx_23060184_axi_sram.sv - AXI4-Lite SRAM slave with programmable response latency
module ysyx_23060184_axi_sram
    import ysyx_23060184_axi_sram_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] SPAN     = (ADDR_W+1)'(DEPTH_WORDS) << 2;
    localparam logic [3:0]      LAT_LOAD = 4'(LATENCY);
    localparam bit              ZERO_LAT = (LATENCY == 0);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    logic              ar_hs, aw_hs, wr_commit;
    logic [ADDR_W-1:0] dec_addr, dec_off;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata, mem_rdata;

    // Reads win over writes when both arrive in the same idle cycle
    assign ar_hs = (state == ST_IDLE) && arvalid;
    assign aw_hs = (state == ST_IDLE) && !arvalid && awvalid && wvalid;

    // In IDLE decode the incoming address, otherwise the latched one
    assign dec_addr = (state == ST_IDLE) ? (arvalid ? araddr : awaddr) : addr_q;
    assign dec_off  = dec_addr - BASE_ADDR;
    assign dec_hit  = (dec_addr >= BASE_ADDR) && ({1'b0, dec_off} < SPAN);
    assign dec_idx  = dec_off[IDX_W+1:2];

    // The write lands on entry to WR_RESP; a reset in that cycle discards it
    assign wr_commit = !rst && (state != ST_WR_RESP) && (state_nxt == ST_WR_RESP) && dec_hit;
    assign mem_we    = wr_commit ? ((state == ST_IDLE) ? wstrb : wstrb_q) : 4'b0000;
    assign mem_wdata = (state == ST_IDLE) ? wdata : wdata_q;

    ysyx_23060184_sram_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .re    (ar_hs),
        .we    (mem_we),
        .addr  (dec_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // State register and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (ar_hs || aw_hs) begin
                cnt <= LAT_LOAD;
            end else if ((state == ST_RD_WAIT || state == ST_WR_WAIT) && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Capture the accepted request for use in the wait and response states
    always_ff @(posedge clk) begin
        if (ar_hs || aw_hs) begin
            addr_q <= dec_addr;
        end
        if (aw_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_nxt = ZERO_LAT ? ST_RD_RESP : ST_RD_WAIT;
                end else if (aw_hs) begin
                    state_nxt = ZERO_LAT ? ST_WR_RESP : ST_WR_WAIT;
                end
            end
            ST_RD_WAIT: if (cnt <= 4'd1) state_nxt = ST_RD_RESP;
            ST_RD_RESP: if (rready)      state_nxt = ST_IDLE;
            ST_WR_WAIT: if (cnt <= 4'd1) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (bready)      state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state; responses use the latched address
    always_comb begin
        arready = (state == ST_IDLE);
        awready = aw_hs;
        wready  = aw_hs;
        rvalid  = (state == ST_RD_RESP);
        bvalid  = (state == ST_WR_RESP);
        rdata   = '0;
        rresp   = RESP_OKAY;
        bresp   = RESP_OKAY;
        if (state == ST_RD_RESP) begin
            rdata = dec_hit ? mem_rdata : '0;
            rresp = dec_hit ? RESP_OKAY : RESP_SLVERR;
        end
        if (state == ST_WR_RESP) begin
            bresp = dec_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_axi_sram.sv
// tb/tb_ysyx_23060184_axi_sram.sv - scoreboard bench for the AXI4-Lite SRAM slave
module tb_ysyx_23060184_axi_sram;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ysyx_23060184_axi_sram #(
        .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h8000_0000),
        .DEPTH_WORDS(1024), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    function automatic bit in_map(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'h8000_0000) >> 2);
    endfunction

    function automatic exp_t expect_read(input logic [31:0] a);
        exp_t e;
        if (in_map(a)) begin
            e.resp = 2'b00;
            e.data = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
        end else begin
            e.resp = 2'b10;
            e.data = 32'h0;
        end
        return e;
    endfunction

    function automatic exp_t expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t        e;
        logic [31:0] w;
        e.data = 32'h0;
        e.resp = in_map(a) ? 2'b00 : 2'b10;
        if (in_map(a)) begin
            w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[widx(a)] = w;
        end
        return e;
    endfunction

    task automatic do_read(input logic [31:0] a);
        exp_t e;
        int   n;
        sb.push_back(expect_read(a));
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        n = 1;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        checks++;
        if (rvalid !== 1'b1 || n != LAT + 1) begin
            errors++;
            $display("FAIL rd_latency addr=%h got %0d cycles rvalid=%b, want %0d", a, n, rvalid, LAT + 1);
        end
        checks++;
        if (rdata !== e.data || rresp !== e.resp) begin
            errors++;
            $display("FAIL rd_data addr=%h got %h/%b, want %h/%b", a, rdata, rresp, e.data, e.resp);
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   n;
        sb.push_back(expect_write(a, d, s));
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 1;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        checks++;
        if (bvalid !== 1'b1 || n != LAT + 1) begin
            errors++;
            $display("FAIL wr_latency addr=%h got %0d cycles bvalid=%b, want %0d", a, n, bvalid, LAT + 1);
        end
        checks++;
        if (bresp !== e.resp) begin
            errors++;
            $display("FAIL wr_resp addr=%h got %b, want %b", a, bresp, e.resp);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid, rresp, bresp} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b, want 100000000",
                     {arready, awready, wready, rvalid, bvalid, rresp, bresp});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h, want 00000000", rdata);
        end
    endtask

    task automatic test_write_read;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        do_read(32'h8000_0010);
    endtask

    task automatic test_partial;
        do_write(32'h8000_0010, 32'h0000_AB00, 4'b0010);
        do_read(32'h8000_0010);
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000);
        do_read(32'h8000_0010);
    endtask

    task automatic test_priority;
        exp_t e;
        int   n;
        sb.push_back(expect_read(32'h8000_0010));
        sb.push_back(expect_write(32'h8000_0014, 32'h0BAD_F00D, 4'hF));
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0014; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL prio_same_cycle got ar/aw/w=%b%b%b, want 100", arready, awready, wready);
        end
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        n = 1;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== e.data || awready !== 1'b0) begin
            errors++;
            $display("FAIL prio_read got rvalid=%b rdata=%h awready=%b, want 1/%h/0", rvalid, rdata, awready, e.data);
        end
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL prio_write_accept got aw/w=%b%b, want 11", awready, wready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 1;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bresp !== e.resp || n != LAT + 1) begin
            errors++;
            $display("FAIL prio_write_resp got bvalid=%b bresp=%b after %0d, want 1/%b after %0d",
                     bvalid, bresp, n, e.resp, LAT + 1);
        end
        @(negedge clk);
        bready = 1'b0;
        do_read(32'h8000_0014);
    endtask

    task automatic test_out_of_range;
        do_write(32'h8000_0000, 32'h1234_5678, 4'hF);
        do_write(32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF);
        do_read(32'h8000_0FFC);
        do_read(32'h7FFF_FFFC);
        do_read(32'h8000_1000);
        do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF);
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF);
        do_read(32'h8000_0000);
    endtask

    task automatic test_stall;
        exp_t e;
        int   n;
        sb.push_back(expect_read(32'h8000_0010));
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b0;
        n = 1;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp || arready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b d=%h r=%b ar=%b, want 1/%h/%b/0",
                         i, rvalid, rdata, rresp, arready, e.data, e.resp);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got rvalid=%b arready=%b, want 0/1", rvalid, arready);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   n;
        @(negedge clk);
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rvalid, bvalid, arready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_rd_wait got r/b/ar=%b, want 001", {rvalid, bvalid, arready});
        end
        rst = 1'b0; rready = 1'b0;
        do_write(32'h8000_0020, 32'h1111_1111, 4'hF);
        @(negedge clk);
        awaddr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rvalid, bvalid, arready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_wr_wait got r/b/ar=%b, want 001", {rvalid, bvalid, arready});
        end
        rst = 1'b0;
        do_read(32'h8000_0020);
        e = expect_write(32'h8000_0024, 32'h55AA_55AA, 4'hF);
        @(negedge clk);
        awaddr = 32'h8000_0024; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        n = 1;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bvalid !== 1'b1 || bresp !== e.resp) begin
            errors++;
            $display("FAIL rst_wr_resp_pre got bvalid=%b bresp=%b, want 1/%b", bvalid, bresp, e.resp);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({rvalid, bvalid, arready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_wr_resp got r/b/ar=%b, want 001", {rvalid, bvalid, arready});
        end
        rst = 1'b0;
        do_read(32'h8000_0024);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_priority();
        test_out_of_range();
        test_stall();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
